// File: rtl/dut_ifc.sv
// Byte-stream packet gate: length tokens release bytes from an input FIFO to the output port.
// Optional macro DUT_CHECKSUM_EN adds a per-packet XOR checksum register at 0x10.
module dut_ifc #(
  parameter int DIN_DEPTH = 8,
  parameter int LEN_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  din_value,
  input  logic        din_en,
  output logic        din_rdy,
  input  logic        dout_en,
  output logic [7:0]  dout_value,
  output logic        dout_rdy,
  input  logic [7:0]  len_value,
  input  logic        len_en,
  output logic        len_rdy,
  input  logic [7:0]  cfg_address,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_op,
  input  logic        cfg_en,
  output logic [31:0] cfg_data_out,
  output logic        cfg_rdy
);

  localparam int DAW = $clog2(DIN_DEPTH);
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int DCW = DAW + 1;
  localparam int LCW = LAW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_PASS = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_live;
  logic           r_ctrl_en;
  logic [7:0]     r_remaining;
  logic [31:0]    r_pkt_cnt;
  logic [31:0]    r_byte_cnt;

  logic [7:0]     r_din_mem [DIN_DEPTH];
  logic [DAW-1:0] r_din_wp, r_din_rp;
  logic [DCW-1:0] r_din_cnt;
  logic [7:0]     r_len_mem [LEN_DEPTH];
  logic [LAW-1:0] r_len_wp, r_len_rp;
  logic [LCW-1:0] r_len_cnt;

  logic           w_din_push, w_dout_pop, w_len_push, w_len_pop, w_last;
  logic           w_cfg_wr, w_clr, w_dout_rdy;
  logic [7:0]     w_len_head;
  logic [31:0]    w_status, w_cksum;
  logic           w_unused;

  // Ready outputs stay low until the first clock after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  assign din_rdy    = r_live && (r_din_cnt != DCW'(DIN_DEPTH));
  assign len_rdy    = r_live && (r_len_cnt != LCW'(LEN_DEPTH));
  assign cfg_rdy    = r_live;
  assign w_din_push = din_en && din_rdy;
  assign w_len_push = len_en && len_rdy;
  assign w_len_head = r_len_mem[r_len_rp];
  assign dout_rdy   = w_dout_rdy;
  assign dout_value = w_dout_rdy ? r_din_mem[r_din_rp] : 8'h00;
  assign w_dout_pop = dout_en && w_dout_rdy;
  assign w_last     = w_dout_pop && (r_remaining == 8'd1);
  assign w_cfg_wr   = cfg_en && cfg_rdy && cfg_op;
  assign w_clr      = w_cfg_wr && (cfg_address == 8'h00) && cfg_data_in[1];
  assign w_unused   = &{1'b0, cfg_data_in[31:2]};

  always_ff @(posedge CLK) begin
    if (w_din_push) r_din_mem[r_din_wp] <= din_value;
    if (w_len_push) r_len_mem[r_len_wp] <= len_value;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_din_wp  <= '0;
      r_din_rp  <= '0;
      r_din_cnt <= '0;
      r_len_wp  <= '0;
      r_len_rp  <= '0;
      r_len_cnt <= '0;
    end else begin
      if (w_din_push) r_din_wp <= r_din_wp + DAW'(1);
      if (w_dout_pop) r_din_rp <= r_din_rp + DAW'(1);
      if (w_din_push && !w_dout_pop)      r_din_cnt <= r_din_cnt + DCW'(1);
      else if (!w_din_push && w_dout_pop) r_din_cnt <= r_din_cnt - DCW'(1);
      if (w_len_push) r_len_wp <= r_len_wp + LAW'(1);
      if (w_len_pop)  r_len_rp <= r_len_rp + LAW'(1);
      if (w_len_push && !w_len_pop)      r_len_cnt <= r_len_cnt + LCW'(1);
      else if (!w_len_push && w_len_pop) r_len_cnt <= r_len_cnt - LCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Zero-length tokens are popped in IDLE but never enter PASS.
  always_comb begin
    w_state_nxt = r_state;
    w_len_pop   = 1'b0;
    w_dout_rdy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_live && r_ctrl_en && (r_len_cnt != '0)) begin
          w_len_pop = 1'b1;
          if (w_len_head != 8'd0) w_state_nxt = S_PASS;
        end
      end
      S_PASS: begin
        w_dout_rdy = (r_din_cnt != '0);
        if (w_dout_rdy && dout_en && (r_remaining == 8'd1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_remaining <= 8'd0;
      r_ctrl_en   <= 1'b1;
      r_pkt_cnt   <= '0;
      r_byte_cnt  <= '0;
    end else begin
      if (w_len_pop)       r_remaining <= w_len_head;
      else if (w_dout_pop) r_remaining <= r_remaining - 8'd1;
      if (w_cfg_wr && (cfg_address == 8'h00)) r_ctrl_en <= cfg_data_in[0];
      if (w_clr)       r_pkt_cnt <= '0;
      else if (w_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_clr)           r_byte_cnt <= '0;
      else if (w_dout_pop) r_byte_cnt <= r_byte_cnt + 32'd1;
    end
  end

`ifdef DUT_CHECKSUM_EN
  logic [7:0] r_ck_acc;
  logic [7:0] r_cksum;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ck_acc <= 8'h00;
      r_cksum  <= 8'h00;
    end else begin
      if (w_dout_pop) r_ck_acc <= w_last ? 8'h00 : (r_ck_acc ^ dout_value);
      if (w_clr)       r_cksum <= 8'h00;
      else if (w_last) r_cksum <= r_ck_acc ^ dout_value;
    end
  end
  assign w_cksum = {24'h0, r_cksum};
`else
  assign w_cksum = 32'h0;
`endif

  assign w_status = {15'h0, (r_state == S_PASS), 8'(r_len_cnt), 8'(r_din_cnt)};

  always_comb begin
    cfg_data_out = 32'h0;
    if (r_live) begin
      case (cfg_address)
        8'h00:   cfg_data_out = {31'h0, r_ctrl_en};
        8'h04:   cfg_data_out = w_status;
        8'h08:   cfg_data_out = r_pkt_cnt;
        8'h0C:   cfg_data_out = r_byte_cnt;
        8'h10:   cfg_data_out = w_cksum;
        default: cfg_data_out = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_ifc.sv
// Self-checking bench for dut_ifc: directed scenarios plus a randomized packet stream
// checked against a queue-based transaction model.
module tb_dut_ifc;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  din_value, dout_value, len_value, cfg_address;
  logic        din_en, din_rdy, dout_en, dout_rdy, len_en, len_rdy;
  logic [31:0] cfg_data_in, cfg_data_out;
  logic        cfg_op, cfg_en, cfg_rdy;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0]  got_q[$];
  logic [31:0] rd;

  always #5 CLK = ~CLK;

  dut_ifc #(.DIN_DEPTH(8), .LEN_DEPTH(2)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    din_value = 8'h00; din_en = 1'b0; dout_en = 1'b0;
    len_value = 8'h00; len_en = 1'b0;
    cfg_address = 8'h00; cfg_data_in = 32'h0; cfg_op = 1'b0; cfg_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic push_din(input logic [7:0] v);
    din_value = v; din_en = 1'b1;
    tick();
    din_en = 1'b0;
  endtask

  task automatic push_len(input logic [7:0] v);
    len_value = v; len_en = 1'b1;
    tick();
    len_en = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_address = a; cfg_data_in = d; cfg_op = 1'b1; cfg_en = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_op = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    cfg_address = a; cfg_op = 1'b0;
    #1;
    d = cfg_data_out;
  endtask

  task automatic drain(input int n);
    got_q.delete();
    dout_en = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < n; i++) begin
      if (dout_rdy) got_q.push_back(dout_value);
      tick();
    end
    dout_en = 1'b0;
    n_checks++;
    if (got_q.size() != n) begin
      n_fails++;
      $display("FAIL drain_timeout: got %0d bytes, expected %0d", got_q.size(), n);
    end
    while (got_q.size() < n) got_q.push_back(8'hxx);
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 1'b0;
    #12;
    n_checks++;
    if ({din_rdy, len_rdy, dout_rdy, cfg_rdy} !== 4'b0000 || cfg_data_out !== 32'h0 || dout_value !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_outputs: rdy=%b cfg=%h dout=%h, expected 0000/0/0",
               {din_rdy, len_rdy, dout_rdy, cfg_rdy}, cfg_data_out, dout_value);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({din_rdy, len_rdy, dout_rdy, cfg_rdy} !== 4'b1101) begin
      n_fails++;
      $display("FAIL idle_rdy: %b expected 1101", {din_rdy, len_rdy, dout_rdy, cfg_rdy});
    end
    cfg_read(8'h00, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fails++; $display("FAIL ctrl_reset: %h expected 1", rd); end
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fails++; $display("FAIL status_reset: %h expected 0", rd); end
  endtask

  task automatic test_packet();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    do_reset();
    push_len(8'd3);
    push_din(8'h11); push_din(8'h22); push_din(8'h33); push_din(8'h44);
    drain(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== exp_b[i]) begin
        n_fails++; $display("FAIL pkt_byte%0d: %h expected %h", i, got_q[i], exp_b[i]);
      end
    end
    dout_en = 1'b1; tick(); tick();
    n_checks++;
    if (dout_rdy !== 1'b0) begin n_fails++; $display("FAIL pkt_end_rdy: %b expected 0", dout_rdy); end
    dout_en = 1'b0;
    cfg_read(8'h08, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fails++; $display("FAIL pkt_count: %0d expected 1", rd); end
    cfg_read(8'h0C, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fails++; $display("FAIL byte_count: %0d expected 3", rd); end
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd[7:0] !== 8'd1) begin n_fails++; $display("FAIL pkt_din_cnt: %0d expected 1", rd[7:0]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) push_din(8'(8'hB0 + i));
    n_checks++;
    if (din_rdy !== 1'b0) begin n_fails++; $display("FAIL full_rdy: %b expected 0", din_rdy); end
    push_din(8'hEE);
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd[7:0] !== 8'd8) begin n_fails++; $display("FAIL full_cnt: %0d expected 8", rd[7:0]); end
    n_checks++;
    if (dout_rdy !== 1'b0) begin n_fails++; $display("FAIL full_dout_rdy: %b expected 0", dout_rdy); end
    push_len(8'd8);
    drain(8);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_q[i] !== 8'(8'hB0 + i)) begin
        n_fails++; $display("FAIL full_byte%0d: %h expected %h", i, got_q[i], 8'(8'hB0 + i));
      end
    end
    tick();
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fails++; $display("FAIL full_drop9: status %h expected 0", rd); end
  endtask

  task automatic test_zero_len();
    do_reset();
    push_len(8'd0);
    push_len(8'd1);
    push_din(8'hA5);
    drain(1);
    n_checks++;
    if (got_q[0] !== 8'hA5) begin n_fails++; $display("FAIL zero_byte: %h expected a5", got_q[0]); end
    tick();
    cfg_read(8'h08, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fails++; $display("FAIL zero_pkt_count: %0d expected 1", rd); end
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fails++; $display("FAIL zero_status: %h expected 0", rd); end
  endtask

  task automatic test_enable_clear();
    do_reset();
    cfg_write(8'h00, 32'h0);
    push_len(8'd2);
    push_din(8'h01); push_din(8'h02);
    repeat (4) tick();
    n_checks++;
    if (dout_rdy !== 1'b0) begin n_fails++; $display("FAIL dis_dout_rdy: %b expected 0", dout_rdy); end
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd[15:8] !== 8'd1) begin n_fails++; $display("FAIL dis_len_cnt: %0d expected 1", rd[15:8]); end
    cfg_write(8'h08, 32'h55);
    cfg_write(8'h00, 32'h1);
    drain(2);
    n_checks++;
    if ({got_q[0], got_q[1]} !== 16'h0102) begin
      n_fails++; $display("FAIL en_bytes: %h%h expected 0102", got_q[0], got_q[1]);
    end
    tick();
    cfg_read(8'h08, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fails++; $display("FAIL ro_write_pkt: %0d expected 1", rd); end
    cfg_write(8'h00, 32'h3);
    cfg_read(8'h08, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fails++; $display("FAIL clr_pkt: %0d expected 0", rd); end
    cfg_read(8'h0C, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fails++; $display("FAIL clr_byte: %0d expected 0", rd); end
    cfg_read(8'h00, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fails++; $display("FAIL clr_ctrl_read: %h expected 1", rd); end
    cfg_read(8'h14, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fails++; $display("FAIL unmapped: %h expected 0", rd); end
  endtask

  task automatic test_checksum();
    logic [31:0] exp_ck;
`ifdef DUT_CHECKSUM_EN
    exp_ck = 32'h0000_00FE;
`else
    exp_ck = 32'h0;
`endif
    do_reset();
    push_len(8'd3);
    push_din(8'h0F); push_din(8'hF0); push_din(8'h01);
    drain(3);
    cfg_read(8'h10, rd);
    n_checks++;
    if (rd !== exp_ck) begin n_fails++; $display("FAIL checksum: %h expected %h", rd, exp_ck); end
    cfg_write(8'h00, 32'h3);
    cfg_read(8'h10, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fails++; $display("FAIL checksum_clr: %h expected 0", rd); end
  endtask

  // Transaction-level model: output stream equals input stream, counters follow token lengths.
  task automatic test_random();
    logic [7:0] lens[$];
    logic [7:0] bytes[$];
    int total, nz, sent, lsent, got, cyc;
    logic [7:0] ck, exp_ck;
    total = 0; nz = 0; exp_ck = 8'h00;
    for (int p = 0; p < 14; p++) begin
      logic [7:0] l;
      l = 8'($urandom_range(0, 6));
      lens.push_back(l);
      ck = 8'h00;
      for (int b = 0; b < l; b++) begin
        logic [7:0] v;
        v = 8'($urandom);
        bytes.push_back(v);
        ck ^= v;
      end
      total += l;
      if (l != 0) begin nz++; exp_ck = ck; end
    end
`ifndef DUT_CHECKSUM_EN
    exp_ck = 8'h00;
`endif
    do_reset();
    sent = 0; lsent = 0; got = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (got == total && lsent == lens.size() && sent == total) break;
      din_en    = (sent < total) && ($urandom_range(0, 3) != 0);
      din_value = (sent < total) ? bytes[sent] : 8'h00;
      len_en    = (lsent < lens.size()) && ($urandom_range(0, 2) != 0);
      len_value = (lsent < lens.size()) ? lens[lsent] : 8'h00;
      dout_en   = ($urandom_range(0, 3) != 0);
      if (din_en && din_rdy) sent++;
      if (len_en && len_rdy) lsent++;
      if (dout_en && dout_rdy) begin
        n_checks++;
        if (got >= total || dout_value !== bytes[got]) begin
          n_fails++;
          $display("FAIL rnd_byte%0d: %h expected %h", got, dout_value, (got < total) ? bytes[got] : 8'hxx);
        end
        got++;
      end
      tick();
    end
    idle_inputs();
    n_checks++;
    if (cyc >= 3000) begin n_fails++; $display("FAIL rnd_timeout: got %0d of %0d bytes", got, total); end
    repeat (4) tick();
    cfg_read(8'h04, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fails++; $display("FAIL rnd_status: %h expected 0", rd); end
    cfg_read(8'h08, rd);
    n_checks++;
    if (rd !== 32'(nz)) begin n_fails++; $display("FAIL rnd_pkt: %0d expected %0d", rd, nz); end
    cfg_read(8'h0C, rd);
    n_checks++;
    if (rd !== 32'(total)) begin n_fails++; $display("FAIL rnd_bytes: %0d expected %0d", rd, total); end
    cfg_read(8'h10, rd);
    n_checks++;
    if (rd !== {24'h0, exp_ck}) begin n_fails++; $display("FAIL rnd_cksum: %h expected %h", rd, exp_ck); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full();
    test_zero_len();
    test_enable_clear();
    test_checksum();
    test_random();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
